// File: rtl/tube_pkg.sv
// Shared definitions for the seven-segment scan master.
//   tube_state_e : scan FSM state encoding
//   TUBE_ALL_OFF : active-low tube-enable pattern with every digit dark
//   SEG_LUT      : active-low {g,f,e,d,c,b,a} patterns for hex 0-F (bit 7 = dp off)
//   tube_en_pattern() : active-low enable pattern selecting one digit
package tube_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrOff = 3'd1,
        StWrSeg = 3'd2,
        StWrEn  = 3'd3,
        StRdEn  = 3'd4,
        StDwell = 3'd5
    } tube_state_e;

    localparam logic [3:0] TUBE_ALL_OFF = 4'hF;

    // Element n is the pattern for hex digit n.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [3:0] tube_en_pattern(input logic [1:0] idx);
        logic [3:0] sel;
        sel = 4'b0001 << idx;
        return TUBE_ALL_OFF & ~sel;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble plus decimal point to active-low segment byte {dp,g,f,e,d,c,b,a}.
//   nibble_i : hex value to display
//   dp_i     : 1 = decimal point lit
//   seg_o    : active-low segment byte
module hex7seg
    import tube_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] lut_byte;

    always_comb begin
        lut_byte = SEG_LUT[nibble_i];
        seg_o    = {~dp_i, lut_byte[6:0]};
    end

endmodule

// File: rtl/tube_scan_master.sv
// Avalon-MM master that refreshes a 4-digit multiplexed seven-segment display.
// Per digit: blank enables, write segment byte, write enable pattern, read enable
// back (mismatch sets sticky err), then hold for DWELL cycles.
//   clk, reset        : clock and synchronous active-high reset
//   enable            : level, 1 = scanning runs
//   digits, dp        : four hex nibbles and decimal points, latched per frame
//   err_clr           : pulse clearing err (a simultaneous new mismatch wins)
//   avm_*             : Avalon-MM master port
//   busy              : FSM not idle
//   digit_idx         : digit currently addressed
//   frame_done        : one-cycle pulse after digit 3 finishes its dwell
//   err               : sticky readback-mismatch flag
module tube_scan_master
    import tube_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     SEG_ADDR = ADDR_W'(32'h0000_0010),
    parameter logic [ADDR_W-1:0]     EN_ADDR  = ADDR_W'(32'h0000_0020),
    parameter int unsigned           DWELL    = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       digits,
    input  logic [3:0]        dp,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [1:0]        digit_idx,
    output logic              frame_done,
    output logic              err
);

    localparam logic [23:0] DwellLoad = 24'(DWELL - 1);

    tube_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_digits_q, shadow_digits_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [23:0] cnt_q, cnt_d;
    logic        stop_q, stop_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;

    logic [3:0]  cur_nibble;
    logic        cur_dp;
    logic [7:0]  cur_seg;
    logic [3:0]  en_pattern;
    logic        xfer_done;
    logic        unused_rd;

    assign unused_rd  = ^avm_readdata[31:4];
    assign cur_nibble = shadow_digits_q[{idx_q, 2'b00} +: 4];
    assign cur_dp     = shadow_dp_q[idx_q];
    assign en_pattern = tube_en_pattern(idx_q);
    assign xfer_done  = ~avm_waitrequest;

    hex7seg u_hex7seg (
        .nibble_i (cur_nibble),
        .dp_i     (cur_dp),
        .seg_o    (cur_seg)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        cnt_d           = cnt_q;
        stop_d          = stop_q;
        frame_done_d    = 1'b0;
        // Clear first so a mismatch in the same cycle overrides it.
        err_d           = err_q & ~err_clr;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    shadow_digits_d = digits;
                    shadow_dp_d     = dp;
                    idx_d           = 2'd0;
                    stop_d          = 1'b0;
                    state_d         = StWrOff;
                end
            end
            StWrOff: begin
                if (xfer_done) begin
                    if (stop_q) begin
                        stop_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StWrSeg;
                    end
                end
            end
            StWrSeg: begin
                if (xfer_done) state_d = StWrEn;
            end
            StWrEn: begin
                if (xfer_done) state_d = StRdEn;
            end
            StRdEn: begin
                if (xfer_done) begin
                    if (avm_readdata[3:0] != en_pattern) err_d = 1'b1;
                    cnt_d   = DwellLoad;
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (cnt_q == 24'd0) begin
                    state_d = StWrOff;
                    if (!enable) begin
                        // Blank the display once more, then park in idle.
                        stop_d = 1'b1;
                    end else if (idx_q == 2'd3) begin
                        frame_done_d    = 1'b1;
                        shadow_digits_d = digits;
                        shadow_dp_d     = dp;
                        idx_d           = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            idx_q           <= 2'd0;
            shadow_digits_q <= 16'h0000;
            shadow_dp_q     <= 4'h0;
            cnt_q           <= 24'd0;
            stop_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            cnt_q           <= cnt_d;
            stop_q          <= stop_d;
            frame_done_q    <= frame_done_d;
            err_q           <= err_d;
        end
    end

    // Bus outputs decode purely from registered state, so they stay constant
    // while waitrequest holds the FSM in place.
    always_comb begin
        avm_address   = '0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = 32'h0;
        case (state_q)
            StWrOff: begin
                avm_address   = EN_ADDR;
                avm_write     = 1'b1;
                avm_writedata = {28'h0, TUBE_ALL_OFF};
            end
            StWrSeg: begin
                avm_address   = SEG_ADDR;
                avm_write     = 1'b1;
                avm_writedata = {24'h0, cur_seg};
            end
            StWrEn: begin
                avm_address   = EN_ADDR;
                avm_write     = 1'b1;
                avm_writedata = {28'h0, en_pattern};
            end
            StRdEn: begin
                avm_address = EN_ADDR;
                avm_read    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tube_scan_master.sv
module tb_tube_scan_master;

    localparam logic [31:0] EN  = 32'h0000_0020;
    localparam logic [31:0] SEG = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset, enable, err_clr, avm_waitrequest;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_write, avm_read, busy, frame_done, err;
    logic [1:0]  digit_idx;

    logic        corrupt;
    logic [3:0]  en_reg;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tube_scan_master #(
        .ADDR_W   (32),
        .SEG_ADDR (32'h0000_0010),
        .EN_ADDR  (32'h0000_0020),
        .DWELL    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .digits          (digits),
        .dp              (dp),
        .err_clr         (err_clr),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .digit_idx       (digit_idx),
        .frame_done      (frame_done),
        .err             (err)
    );

    // Enable PIO slave model; corrupt forces an all-off readback.
    always @(posedge clk) begin
        if (reset) en_reg <= 4'hF;
        else if (avm_write && !avm_waitrequest && avm_address == EN) en_reg <= avm_writedata[3:0];
    end
    assign avm_readdata = corrupt ? 32'h0000_000F : {28'h0, en_reg};

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
        chk(tag, {avm_write, avm_read, avm_address, avm_writedata}, {w, r, a, d});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; digits = 16'h1234; dp = 4'h0; err_clr = 1'b0;
        avm_waitrequest = 1'b0; corrupt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 66'(busy), 66'(0));
        bus("rst_bus", 0, 0, 0, 0);
        chk("rst_idx", 66'(digit_idx), 66'(0));
        chk("rst_fd", 66'(frame_done), 66'(0));
        chk("rst_err", 66'(err), 66'(0));
        reset = 1'b0; enable = 1'b1;

        @(negedge clk); // frame cycle 0
        bus("f0d0_off", 1, 0, EN, 32'hF);
        chk("f0d0_busy", 66'(busy), 66'(1));
        @(negedge clk); bus("f0d0_seg", 1, 0, SEG, 32'h99);
        @(negedge clk); bus("f0d0_en", 1, 0, EN, 32'hE);
        @(negedge clk); bus("f0d0_rd", 0, 1, EN, 32'h0);
        @(negedge clk); bus("f0d0_dw", 0, 0, 0, 0);
        chk("f0d0_dw_busy", 66'(busy), 66'(1));
        repeat (4) @(negedge clk); // 8
        bus("f0d1_off", 1, 0, EN, 32'hF);
        chk("f0d1_idx", 66'(digit_idx), 66'(1));
        @(negedge clk); bus("f0d1_seg", 1, 0, SEG, 32'hB0);
        @(negedge clk); bus("f0d1_en", 1, 0, EN, 32'hD); // 10
        digits = 16'hABCD; dp = 4'b0001;
        repeat (7) @(negedge clk); // 17
        bus("f0d2_seg_old", 1, 0, SEG, 32'hA4);
        repeat (8) @(negedge clk); // 25
        bus("f0d3_seg_old", 1, 0, SEG, 32'hF9);
        chk("f0d3_idx", 66'(digit_idx), 66'(3));
        repeat (6) @(negedge clk); // 31
        chk("fd_before", 66'(frame_done), 66'(0));
        @(negedge clk); // 32
        chk("fd_pulse", 66'(frame_done), 66'(1));
        chk("f1_idx_wrap", 66'(digit_idx), 66'(0));
        bus("f1d0_off", 1, 0, EN, 32'hF);

        // Stall the segment write for three cycles.
        @(negedge clk); // 33
        chk("fd_after", 66'(frame_done), 66'(0));
        bus("f1d0_seg_w0", 1, 0, SEG, 32'h21);
        avm_waitrequest = 1'b1;
        @(negedge clk); bus("f1d0_seg_w1", 1, 0, SEG, 32'h21);
        @(negedge clk); bus("f1d0_seg_w2", 1, 0, SEG, 32'h21);
        @(negedge clk); bus("f1d0_seg_w3", 1, 0, SEG, 32'h21); // 36
        avm_waitrequest = 1'b0;
        @(negedge clk); bus("f1d0_en", 1, 0, EN, 32'hE); // 37
        corrupt = 1'b1;
        @(negedge clk); bus("f1d0_rd", 0, 1, EN, 32'h0); // 38
        chk("err_pre", 66'(err), 66'(0));
        @(negedge clk); chk("err_set", 66'(err), 66'(1)); // 39
        corrupt = 1'b0;
        @(negedge clk); chk("err_sticky", 66'(err), 66'(1)); // 40
        err_clr = 1'b1;
        @(negedge clk); chk("err_clr", 66'(err), 66'(0)); // 41
        err_clr = 1'b0;
        repeat (3) @(negedge clk); bus("f1d1_seg", 1, 0, SEG, 32'hC6); // 44
        @(negedge clk); bus("f1d1_en", 1, 0, EN, 32'hD);
        @(negedge clk); bus("f1d1_rd", 0, 1, EN, 32'h0); // 46
        corrupt = 1'b1; err_clr = 1'b1;
        @(negedge clk); chk("err_set_wins", 66'(err), 66'(1)); // 47
        corrupt = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk); bus("f1d2_seg", 1, 0, SEG, 32'h83); // 52

        // Drop enable during WR_EN of digit 2.
        @(negedge clk); bus("f1d2_en", 1, 0, EN, 32'hB); // 53
        enable = 1'b0;
        @(negedge clk); bus("stop_rd", 0, 1, EN, 32'h0);
        chk("stop_idx", 66'(digit_idx), 66'(2));
        @(negedge clk); bus("stop_dw", 0, 0, 0, 0);
        chk("stop_dw_busy", 66'(busy), 66'(1));
        repeat (4) @(negedge clk); bus("stop_off", 1, 0, EN, 32'hF); // 59
        @(negedge clk); bus("stop_idle", 0, 0, 0, 0); // 60
        chk("stop_busy", 66'(busy), 66'(0));
        chk("stop_err_kept", 66'(err), 66'(1));
        @(negedge clk); chk("stop_stay", 66'(busy), 66'(0)); // 61
        enable = 1'b1;

        // Reset in the middle of a stalled write.
        @(negedge clk); bus("rs_off", 1, 0, EN, 32'hF); // 62
        avm_waitrequest = 1'b1;
        @(negedge clk); bus("rs_off_hold", 1, 0, EN, 32'hF); // 63
        reset = 1'b1;
        @(negedge clk); // 64
        chk("rs_write", 66'(avm_write), 66'(0));
        chk("rs_busy", 66'(busy), 66'(0));
        chk("rs_err", 66'(err), 66'(0));
        chk("rs_idx", 66'(digit_idx), 66'(0));
        reset = 1'b0; avm_waitrequest = 1'b0; enable = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
